writeback: RTL and testbench
============================

Name: writeback

Overview:
- Final pipeline stage, directly downstream of the memory stage; consumes its registered outputs.
- Formats load data, selects the register-file write value, and drives the register-file and CSR write ports.
- Sequences traps (exceptions, interrupts), mret and wfi. Issues the redirect/invalidate to earlier stages, and the trap-entry and retire strobes to the CSR unit.

Parameters:
- IRQ_ENABLE, 1, when 0 interrupts are never taken; irq_pending is ignored.
- ECAUSE_W, 4, width of exception cause fields.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_in  in  32  pc of entry.
- next_pc_in  in  32  pc+4 of entry.
- alu_data_in  in  32  ALU result / memory address.
- csr_data_in  in  32  CSR read value.
- load_data_in  in  32  raw aligned memory word.
- load_store_size  in  2  00 byte, 01 half, 10 word.
- load_signed  in  1  sign-extend load.
- write_select_in  in  2  00 alu, 01 csr, 10 load, 11 next_pc.
- rd_addr_in  in  5  destination register.
- csr_addr_in  in  12  CSR address.
- mret_in, wfi_in  in  1  instruction flags.
- valid_in  in  1  entry present.
- exception_in  in  1  entry carries exception.
- ecause_in  in  ECAUSE_W  exception cause.
- stall_in  in  1  hold (memory stage not ready).
- irq_pending  in  1  enabled interrupt pending (from CSR unit).
- irq_cause  in  ECAUSE_W  interrupt cause.
- mtvec_in  in  32  trap vector.
- mepc_in  in  32  mret target.
- data_hazard  out  5  rd of uncommitted entry, 0 if none.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- csr_we  out  1  CSR write enable.
- csr_waddr  out  12  CSR write address.
- csr_wdata  out  32  CSR write data.
- trap_out  out  1  trap-entry strobe.
- trap_epc  out  32  value for mepc.
- trap_cause  out  32  value for mcause.
- mret_out  out  1  mret strobe.
- retire  out  1  instruction-retired strobe.
- redirect  out  1  registered: invalidate earlier stages and branch.
- redirect_addr  out  32  registered branch target.
- stall_out  out  1  hold upstream.

Behaviour:
- Commit is combinational in the presentation cycle: commit = valid_in && !stall_in && state==RUN && !take_irq. All strobes are single-cycle and qualified by commit (or take_irq).
- Load formatting uses alu_data_in[1:0]:
  - byte: lane = addr[1:0]*8.
  - half: lane = addr[1]*16.
  - Sign- or zero-extend per load_signed.
  - Size 11 is treated as word.
- rf_we = commit && !exception_in && rd_addr_in!=0 && !trap. rf_wdata is selected per write_select_in.
- csr_we = commit && !exception_in && write_select_in==01. csr_wdata = alu_data_in.
- Exception (commit && exception_in):
  - trap_out=1, trap_epc=pc_in, trap_cause={0,ecause_in}.
  - No rf/csr write; retire=0.
- Interrupt: take_irq = IRQ_ENABLE && irq_pending && valid_in && !stall_in && state==RUN.
  - Interrupts take priority over a pending exception.
  - trap_out=1, trap_epc=pc_in, trap_cause={1,27'b0,irq_cause}.
  - The entry is not committed.
- mret (commit, no exception): mret_out=1, retire=1, redirect to mepc_in.
- Trap redirect target: mtvec_in with bits [1:0] cleared.
- redirect and redirect_addr are registered:
  - They assert the cycle after the trap or mret, for exactly one cycle.
  - They return to 0 otherwise.
- retire = commit && !exception_in.
- data_hazard = rd_addr_in when valid_in && !exception_in && state==RUN, else 0.
- FSM states: RUN, WFI.
  - RUN→WFI: wfi_in committed without exception; wfi retires on that cycle.
  - In WFI: stall_out=1 and no commits.
  - WFI→RUN: when irq_pending=1, regardless of IRQ_ENABLE. The interrupt, if enabled, is taken on the held next entry. The wakeup cycle itself only leaves WFI.
  - stall_out = stall_in || state==WFI.
- Simultaneous exception_in and wfi_in/mret_in: the exception wins.
- Asynchronous reset: state=RUN, redirect=0, redirect_addr=0. All combinational outputs follow their inputs, so they are 0 when valid_in=0.

Decomposition:
- Shared package holds:
  - write_select encodings.
  - load_store_size encodings.
  - Exception cause constants: 0 misaligned fetch, 2 illegal, 3 breakpoint, 4 misaligned load, 6 misaligned store, 11 ecall.
  - FSM state type.
- One natural sub-module: load_align (pure combinational lane select and extend).

Test Plan:
- Load byte signed: addr=0x1003, load_data_in=0x80FFFFFF, size 00, signed, rd=5 → rf_we=1, rf_waddr=5, rf_wdata=0xFFFFFF80, retire=1.
- Exception: pc_in=0x200, ecause_in=4, exception_in=1, rd=7 → trap_out=1, trap_epc=0x200, trap_cause=4, rf_we=0; next cycle redirect=1, redirect_addr=mtvec_in&~3.
- Write to x0 via write_select 11: rd=0, next_pc_in=0x104 → rf_we=0, retire=1.
- mret: mepc_in=0x400 → mret_out=1; next cycle redirect=1, redirect_addr=0x400.
- wfi, then idle 5 cycles, then irq_pending=1 with irq_cause=7 and next entry pc=0x300:
  - stall_out=1 for all 5 idle cycles.
  - After wakeup: trap_cause=0x80000007, trap_epc=0x300.
- Reset asserted mid-redirect (the cycle redirect=1): redirect drops to 0 immediately without a clock edge; state returns to RUN.

Source files
------------

// File: rtl/writeback_pkg.sv
// writeback_pkg: shared encodings for the writeback stage.
//   - write_select encodings (register-file write source)
//   - load_store_size encodings
//   - exception cause constants
//   - FSM state type and state constants
package writeback_pkg;

  // Register-file write source
  localparam logic [1:0] WS_ALU    = 2'b00;
  localparam logic [1:0] WS_CSR    = 2'b01;
  localparam logic [1:0] WS_LOAD   = 2'b10;
  localparam logic [1:0] WS_NEXTPC = 2'b11;

  // Memory access size (2'b11 is treated as a word)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Exception causes
  localparam int unsigned EC_MISALIGNED_FETCH = 0;
  localparam int unsigned EC_ILLEGAL          = 2;
  localparam int unsigned EC_BREAKPOINT       = 3;
  localparam int unsigned EC_MISALIGNED_LOAD  = 4;
  localparam int unsigned EC_MISALIGNED_STORE = 6;
  localparam int unsigned EC_ECALL            = 11;

  // Sequencer states
  typedef logic [0:0] wb_state_t;
  localparam wb_state_t ST_RUN = 1'b0;
  localparam wb_state_t ST_WFI = 1'b1;

endpackage

// File: rtl/writeback_load_align.sv
// writeback_load_align: purely combinational load formatter.
//   data      - raw aligned 32-bit memory word
//   addr_lo   - byte offset of the access within the word
//   size      - access size (byte/half/word, 2'b11 treated as word)
//   is_signed - sign-extend (1) or zero-extend (0) sub-word loads
//   result    - lane-selected, extended value
module writeback_load_align
  import writeback_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  // Move the addressed lane down to bit 0 before extending.
  assign byte_shift = data >> {addr_lo, 3'b000};
  assign half_shift = data >> {addr_lo[1], 4'b0000};

  always_comb begin
    result = data;
    case (size)
      SZ_BYTE: result = {{24{is_signed & byte_shift[7]}}, byte_shift[7:0]};
      SZ_HALF: result = {{16{is_signed & half_shift[15]}}, half_shift[15:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// writeback: final pipeline stage.
//   Inputs : registered entry from the memory stage (pc, next_pc, alu/csr/load
//            data, control flags, exception info), stall_in, interrupt request
//            and the trap vector / mret target from the CSR unit.
//   Outputs: register-file and CSR write ports, trap-entry / mret / retire
//            strobes, registered redirect to earlier stages, data_hazard rd
//            and stall_out.
//   Commit happens combinationally in the cycle an entry is presented; only
//   the sequencer state and the redirect are registered.
module writeback
  import writeback_pkg::*;
#(
  parameter bit IRQ_ENABLE = 1'b1,
  parameter int ECAUSE_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc_in,
  input  logic [31:0]         next_pc_in,
  input  logic [31:0]         alu_data_in,
  input  logic [31:0]         csr_data_in,
  input  logic [31:0]         load_data_in,
  input  logic [1:0]          load_store_size,
  input  logic                load_signed,
  input  logic [1:0]          write_select_in,
  input  logic [4:0]          rd_addr_in,
  input  logic [11:0]         csr_addr_in,
  input  logic                mret_in,
  input  logic                wfi_in,
  input  logic                valid_in,
  input  logic                exception_in,
  input  logic [ECAUSE_W-1:0] ecause_in,
  input  logic                stall_in,
  input  logic                irq_pending,
  input  logic [ECAUSE_W-1:0] irq_cause,
  input  logic [31:0]         mtvec_in,
  input  logic [31:0]         mepc_in,
  output logic [4:0]          data_hazard,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic                csr_we,
  output logic [11:0]         csr_waddr,
  output logic [31:0]         csr_wdata,
  output logic                trap_out,
  output logic [31:0]         trap_epc,
  output logic [31:0]         trap_cause,
  output logic                mret_out,
  output logic                retire,
  output logic                redirect,
  output logic [31:0]         redirect_addr,
  output logic                stall_out
);

  wb_state_t   state_reg;
  wb_state_t   state_next;
  logic        running;
  logic        take_irq;
  logic        commit;
  logic        commit_ok;   // committed and not excepting
  logic        trap;
  logic [31:0] load_value;

  writeback_load_align u_load_align (
    .data      (load_data_in),
    .addr_lo   (alu_data_in[1:0]),
    .size      (load_store_size),
    .is_signed (load_signed),
    .result    (load_value)
  );

  assign running  = (state_reg == ST_RUN);
  // An interrupt steals the presented entry; it is replayed after the handler.
  assign take_irq = IRQ_ENABLE && irq_pending && valid_in && !stall_in && running;
  assign commit   = valid_in && !stall_in && running && !take_irq;
  assign commit_ok = commit && !exception_in;
  assign trap     = take_irq || (commit && exception_in);

  // Register-file port
  always_comb begin
    rf_wdata = alu_data_in;
    case (write_select_in)
      WS_CSR:    rf_wdata = csr_data_in;
      WS_LOAD:   rf_wdata = load_value;
      WS_NEXTPC: rf_wdata = next_pc_in;
      default:   rf_wdata = alu_data_in;
    endcase
  end
  assign rf_we    = commit_ok && (rd_addr_in != 5'd0) && !trap;
  assign rf_waddr = rd_addr_in;

  // CSR port
  assign csr_we    = commit_ok && (write_select_in == WS_CSR);
  assign csr_waddr = csr_addr_in;
  assign csr_wdata = alu_data_in;

  // Trap / mret / retire strobes
  assign trap_out   = trap;
  assign trap_epc   = pc_in;
  assign trap_cause = take_irq ? {1'b1, {(31-ECAUSE_W){1'b0}}, irq_cause}
                               : {{(32-ECAUSE_W){1'b0}}, ecause_in};
  assign mret_out   = commit_ok && mret_in;
  assign retire     = commit_ok;

  assign data_hazard = (valid_in && !exception_in && running) ? rd_addr_in : 5'd0;
  assign stall_out   = stall_in || (state_reg == ST_WFI);

  // Any pending interrupt wakes the core, even if interrupts are not taken.
  always_comb begin
    state_next = state_reg;
    if (running) begin
      if (commit_ok && wfi_in)
        state_next = ST_WFI;
    end else if (irq_pending) begin
      state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      redirect      <= 1'b0;
      redirect_addr <= 32'd0;
    end else begin
      state_reg <= state_next;
      redirect  <= trap || mret_out;
      if (trap)
        redirect_addr <= mtvec_in & ~32'h3;
      else if (mret_out)
        redirect_addr <= mepc_in;
      else
        redirect_addr <= 32'd0;
    end
  end

endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed self-checking bench for writeback.
module tb_writeback;
  import writeback_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in;
  logic [1:0]  load_store_size;
  logic        load_signed;
  logic [1:0]  write_select_in;
  logic [4:0]  rd_addr_in;
  logic [11:0] csr_addr_in;
  logic        mret_in, wfi_in, valid_in, exception_in;
  logic [3:0]  ecause_in;
  logic        stall_in, irq_pending;
  logic [3:0]  irq_cause;
  logic [31:0] mtvec_in, mepc_in;
  logic [4:0]  data_hazard;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        trap_out;
  logic [31:0] trap_epc, trap_cause;
  logic        mret_out, retire, redirect;
  logic [31:0] redirect_addr;
  logic        stall_out;

  int vectors = 0;
  int miscompares = 0;

  writeback #(.IRQ_ENABLE(1'b1), .ECAUSE_W(4)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .next_pc_in(next_pc_in),
    .alu_data_in(alu_data_in), .csr_data_in(csr_data_in),
    .load_data_in(load_data_in), .load_store_size(load_store_size),
    .load_signed(load_signed), .write_select_in(write_select_in),
    .rd_addr_in(rd_addr_in), .csr_addr_in(csr_addr_in), .mret_in(mret_in),
    .wfi_in(wfi_in), .valid_in(valid_in), .exception_in(exception_in),
    .ecause_in(ecause_in), .stall_in(stall_in), .irq_pending(irq_pending),
    .irq_cause(irq_cause), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .data_hazard(data_hazard), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .trap_out(trap_out), .trap_epc(trap_epc),
    .trap_cause(trap_cause), .mret_out(mret_out), .retire(retire),
    .redirect(redirect), .redirect_addr(redirect_addr), .stall_out(stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; registered outputs are
  // then already settled, combinational outputs settle after a further #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_in = 0; next_pc_in = 0; alu_data_in = 0; csr_data_in = 0;
    load_data_in = 0; load_store_size = SZ_WORD; load_signed = 0;
    write_select_in = WS_ALU; rd_addr_in = 0; csr_addr_in = 0;
    mret_in = 0; wfi_in = 0; valid_in = 0; exception_in = 0; ecause_in = 0;
    stall_in = 0; irq_pending = 0; irq_cause = 0;
    mtvec_in = 32'h0000_1003; mepc_in = 0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data,
                      input logic [1:0] size, input logic sgn, input logic [4:0] rd);
    idle();
    valid_in = 1; write_select_in = WS_LOAD; alu_data_in = addr;
    load_data_in = data; load_store_size = size; load_signed = sgn; rd_addr_in = rd;
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #12;
    chk("reset_redirect", 32'(redirect), 32'd0);
    chk("reset_redirect_addr", redirect_addr, 32'd0);
    chk("reset_stall_out", 32'(stall_out), 32'd0);
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_hazard", 32'(data_hazard), 32'd0);
    reset = 1'b0;
    tick();

    // Signed byte load from lane 3
    load(32'h0000_1003, 32'h80FF_FFFF, SZ_BYTE, 1'b1, 5'd5);
    chk("lb_rf_we", 32'(rf_we), 32'd1);
    chk("lb_rf_waddr", 32'(rf_waddr), 32'd5);
    chk("lb_rf_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("lb_retire", 32'(retire), 32'd1);
    chk("lb_hazard", 32'(data_hazard), 32'd5);
    chk("lb_trap", 32'(trap_out), 32'd0);
    tick();
    chk("lb_no_redirect", 32'(redirect), 32'd0);

    // Unsigned byte lane 1, unsigned upper half, size 11 as word, signed half
    load(32'h0000_0001, 32'h0000_A500, SZ_BYTE, 1'b0, 5'd3);
    chk("lbu_lane1", rf_wdata, 32'h0000_00A5);
    tick();
    load(32'h0000_0002, 32'h8001_1234, SZ_HALF, 1'b0, 5'd3);
    chk("lhu_upper", rf_wdata, 32'h0000_8001);
    tick();
    load(32'h0000_0000, 32'h1234_8765, SZ_HALF, 1'b1, 5'd3);
    chk("lh_lower_signed", rf_wdata, 32'hFFFF_8765);
    tick();
    load(32'h0000_0000, 32'hCAFE_BABE, 2'b11, 1'b1, 5'd3);
    chk("lw_size11", rf_wdata, 32'hCAFE_BABE);
    tick();

    // Exception: misaligned load
    idle();
    valid_in = 1; pc_in = 32'h200; exception_in = 1;
    ecause_in = 4'(EC_MISALIGNED_LOAD); rd_addr_in = 5'd7; write_select_in = WS_CSR;
    #1;
    chk("exc_trap", 32'(trap_out), 32'd1);
    chk("exc_epc", trap_epc, 32'h200);
    chk("exc_cause", trap_cause, 32'd4);
    chk("exc_rf_we", 32'(rf_we), 32'd0);
    chk("exc_csr_we", 32'(csr_we), 32'd0);
    chk("exc_retire", 32'(retire), 32'd0);
    chk("exc_hazard", 32'(data_hazard), 32'd0);
    tick();
    idle();
    chk("exc_redirect", 32'(redirect), 32'd1);
    chk("exc_redirect_addr", redirect_addr, 32'h0000_1000);
    tick();
    chk("exc_redirect_drop", 32'(redirect), 32'd0);
    chk("exc_redirect_addr_drop", redirect_addr, 32'd0);

    // Write to x0 through next_pc select
    idle();
    valid_in = 1; rd_addr_in = 0; write_select_in = WS_NEXTPC; next_pc_in = 32'h104;
    #1;
    chk("x0_rf_we", 32'(rf_we), 32'd0);
    chk("x0_retire", 32'(retire), 32'd1);
    tick();

    // CSR write with rd
    idle();
    valid_in = 1; rd_addr_in = 5'd9; write_select_in = WS_CSR;
    csr_addr_in = 12'h305; alu_data_in = 32'h0000_DEAD; csr_data_in = 32'h1111_2222;
    #1;
    chk("csr_we", 32'(csr_we), 32'd1);
    chk("csr_waddr", 32'(csr_waddr), 32'h305);
    chk("csr_wdata", csr_wdata, 32'h0000_DEAD);
    chk("csr_rf_wdata", rf_wdata, 32'h1111_2222);
    tick();

    // Stalled entry does not commit
    idle();
    valid_in = 1; stall_in = 1; rd_addr_in = 5'd4;
    #1;
    chk("stall_retire", 32'(retire), 32'd0);
    chk("stall_rf_we", 32'(rf_we), 32'd0);
    chk("stall_out", 32'(stall_out), 32'd1);
    tick();

    // mret
    idle();
    valid_in = 1; mret_in = 1; mepc_in = 32'h400;
    #1;
    chk("mret_out", 32'(mret_out), 32'd1);
    chk("mret_retire", 32'(retire), 32'd1);
    chk("mret_trap", 32'(trap_out), 32'd0);
    tick();
    idle();
    chk("mret_redirect", 32'(redirect), 32'd1);
    chk("mret_redirect_addr", redirect_addr, 32'h400);

    // Exception beats mret
    idle();
    valid_in = 1; mret_in = 1; exception_in = 1; ecause_in = 4'(EC_ILLEGAL);
    #1;
    chk("excmret_mret_out", 32'(mret_out), 32'd0);
    chk("excmret_cause", trap_cause, 32'd2);
    tick();

    // wfi, 5 idle cycles, then wake and take interrupt on held entry
    idle();
    valid_in = 1; wfi_in = 1;
    #1;
    chk("wfi_retire", 32'(retire), 32'd1);
    chk("wfi_stall_before", 32'(stall_out), 32'd0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("wfi_idle%0d_stall", i), 32'(stall_out), 32'd1);
      tick();
    end
    idle();
    valid_in = 1; pc_in = 32'h300; irq_pending = 1; irq_cause = 4'd7;
    exception_in = 1; ecause_in = 4'(EC_ECALL);
    #1;
    chk("wake_trap", 32'(trap_out), 32'd0);
    chk("wake_stall", 32'(stall_out), 32'd1);
    chk("wake_retire", 32'(retire), 32'd0);
    tick();
    chk("irq_trap", 32'(trap_out), 32'd1);
    chk("irq_cause", trap_cause, 32'h8000_0007);
    chk("irq_epc", trap_epc, 32'h300);
    chk("irq_retire", 32'(retire), 32'd0);
    chk("irq_stall", 32'(stall_out), 32'd0);
    tick();
    idle();
    chk("irq_redirect", 32'(redirect), 32'd1);
    chk("irq_redirect_addr", redirect_addr, 32'h0000_1000);

    // Asynchronous reset while redirect is high
    reset = 1'b1;
    #1;
    chk("arst_redirect", 32'(redirect), 32'd0);
    chk("arst_redirect_addr", redirect_addr, 32'd0);
    reset = 1'b0;
    tick();

    // Reset out of WFI returns to RUN
    valid_in = 1; wfi_in = 1;
    tick();
    idle();
    chk("wfi2_stall", 32'(stall_out), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_wfi_stall", 32'(stall_out), 32'd0);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
